// File: rtl/word_deser.sv
// Serial-to-parallel frame receiver: start bit + WIDTH data bits -> Q, QV/QR handshake; QV one edge after last bit.
// Optional even-parity trailer bit enabled by WORD_DESER_PARITY_CHECK_EN; a start seen while a word is held is dropped (OVR).
module word_deser #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SI,
  input  logic             SV,
  input  logic             QR,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic             OVR,
  output logic             ERR
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef WORD_DESER_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d;
  logic             ovr_q, ovr_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (MSB_FIRST) shifted = {sh_q[WIDTH-2:0], SI};
    else           shifted = {SI, sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    q_d     = q_q;
    qv_d    = qv_q;
    ovr_d   = 1'b0;
    err_d   = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (SV && SI) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (SV) begin
          sh_d  = shifted;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
`ifdef WORD_DESER_PARITY_CHECK_EN
            state_d = PAR;
`else
            q_d     = shifted;
            qv_d    = 1'b1;
            state_d = HOLD;
`endif
          end
        end
      end
`ifdef WORD_DESER_PARITY_CHECK_EN
      PAR: begin
        if (SV) begin
          if (SI == ^sh_q) begin
            q_d     = sh_q;
            qv_d    = 1'b1;
            state_d = HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      HOLD: begin
        if (QR) begin
          qv_d   = 1'b0;
          drop_d = 1'b0;
          if (SV && SI) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (SV && SI && !drop_q) begin
          // Rest of the dropped frame is line noise until the consumer drains Q.
          ovr_d  = 1'b1;
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign Q   = q_q;
  assign QV  = qv_q;
  assign OVR = ovr_q;
  assign ERR = err_q;

endmodule
